// File: rtl/mem_port_arbiter_if.sv
// Request/grant/response bundle between the three memory requesters,
// the unified RAM and mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic [3:0]        ld_be;
  logic              ld_gnt;
  logic              ld_rvalid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;

  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_be,
    output ld_gnt, ld_rvalid,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid,
    input  i_req, i_addr,
    output i_gnt, i_rvalid,
    output rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, ld_be,
    input  ld_gnt, ld_rvalid,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid,
    output i_req, i_addr,
    input  i_gnt, i_rvalid,
    input  rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter: loader > data > fetch, with a
// starvation override for fetch and error responses for bad addresses.
module mem_port_arbiter #(
  parameter int MEM_WORDS    = 4096,
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W:0] LIM_A = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [CW-1:0]   LIM_S = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LD,
    OWN_D,
    OWN_I
  } owner_e;

  owner_e            win;
  owner_e            owner_q;
  logic              err_q;
  logic [CW-1:0]     starve_q;
  logic              force_i;
  logic              addr_ok;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  assign force_i = bus.i_req && (starve_q == LIM_S);

  // Conditions are written mutually exclusive so the decoder stays one-hot.
  always_comb begin
    win = OWN_NONE;
    unique case (1'b1)
      rst_n && bus.ld_req:
        win = OWN_LD;
      rst_n && !bus.ld_req && bus.d_req && !force_i:
        win = OWN_D;
      rst_n && !bus.ld_req && bus.i_req && (!bus.d_req || force_i):
        win = OWN_I;
      default:
        win = OWN_NONE;
    endcase
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = 4'h0;
    sel_addr  = '0;
    sel_wdata = 32'h0;
    case (win)
      OWN_LD: begin
        sel_we    = bus.ld_we;
        sel_be    = bus.ld_be;
        sel_addr  = bus.ld_addr;
        sel_wdata = bus.ld_wdata;
      end
      OWN_D: begin
        sel_we    = bus.d_we;
        sel_be    = bus.d_be;
        sel_addr  = bus.d_addr;
        sel_wdata = bus.d_wdata;
      end
      OWN_I: begin
        sel_be   = 4'hF;
        sel_addr = bus.i_addr;
      end
      default: ;
    endcase
  end

  assign addr_ok = ({1'b0, sel_addr} < LIM_A);

  assign bus.ld_gnt    = (win == OWN_LD);
  assign bus.d_gnt     = (win == OWN_D);
  assign bus.i_gnt     = (win == OWN_I);

  assign bus.mem_en    = (win != OWN_NONE) && addr_ok;
  assign bus.mem_we    = sel_we;
  assign bus.mem_be    = sel_be;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q <= win;
      err_q   <= (win != OWN_NONE) && !addr_ok;
      if (bus.i_req && (win != OWN_I)) begin
        if (starve_q != LIM_S)
          starve_q <= starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
    end
  end

  assign bus.ld_rvalid = (owner_q == OWN_LD);
  assign bus.d_rvalid  = (owner_q == OWN_D);
  assign bus.i_rvalid  = (owner_q == OWN_I);

  assign bus.rsp_err   = (owner_q != OWN_NONE) && err_q;
  assign bus.rsp_rdata = ((owner_q != OWN_NONE) && !err_q)
                         ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read RAM model.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_mem_port_arbiter;

  localparam int AW = 13;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_tot;

  logic [31:0] ram [0:4095];

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_port_arbiter #(
    .MEM_WORDS   (4096),
    .ADDR_W      (AW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b])
            ram[bus.mem_addr[11:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      bus.mem_rdata <= ram[bus.mem_addr[11:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    for (int k = 0; k < 4096; k++) ram[k] = 32'h0;
    ram[12'h010] = 32'h0000_0013;
    ram[12'h030] = 32'h1111_2222;
    ram[12'h040] = 32'h3333_4444;
    bus.mem_rdata = 32'h0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0;
    bus.ld_wdata = 0; bus.ld_be = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = 0; bus.d_be = 0;
    bus.i_req = 0; bus.i_addr = '0;
    rst_n = 1'b0;

    // reset: requests ignored, everything zero
    tick();
    bus.i_req = 1; bus.i_addr = 13'h010;
    mid();
    chk("rst_i_gnt", bus.i_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_i_rvalid", bus.i_rvalid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    tick();
    bus.i_req = 0;
    rst_n = 1'b1;

    // single fetch read
    tick();
    bus.i_req = 1; bus.i_addr = 13'h010;
    mid();
    chk("f_i_gnt", bus.i_gnt, 1);
    chk("f_mem_en", bus.mem_en, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h010);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_mem_be", bus.mem_be, 32'hF);
    tick();
    bus.i_req = 0;
    mid();
    chk("f_i_rvalid", bus.i_rvalid, 1);
    chk("f_rdata", bus.rsp_rdata, 32'h13);
    chk("f_err", bus.rsp_err, 0);
    chk("f_i_gnt_off", bus.i_gnt, 0);

    // three-way contention
    tick();
    bus.ld_req = 1; bus.ld_addr = 13'h030;
    bus.d_req = 1; bus.d_addr = 13'h040;
    bus.i_req = 1; bus.i_addr = 13'h010;
    mid();
    chk("c_ld_gnt", bus.ld_gnt, 1);
    chk("c_d_gnt0", bus.d_gnt, 0);
    chk("c_i_gnt0", bus.i_gnt, 0);
    chk("c_mem_addr", bus.mem_addr, 32'h030);
    tick();
    bus.ld_req = 0;
    mid();
    chk("c_ld_rvalid", bus.ld_rvalid, 1);
    chk("c_ld_rdata", bus.rsp_rdata, 32'h1111_2222);
    chk("c_d_gnt", bus.d_gnt, 1);
    chk("c_i_gnt1", bus.i_gnt, 0);
    tick();
    bus.d_req = 0;
    mid();
    chk("c_d_rvalid", bus.d_rvalid, 1);
    chk("c_ld_rvalid0", bus.ld_rvalid, 0);
    chk("c_d_rdata", bus.rsp_rdata, 32'h3333_4444);
    chk("c_i_gnt", bus.i_gnt, 1);
    tick();
    bus.i_req = 0;
    mid();
    chk("c_i_rvalid", bus.i_rvalid, 1);
    chk("c_d_rvalid0", bus.d_rvalid, 0);
    chk("c_i_rdata", bus.rsp_rdata, 32'h13);

    // starvation: data wins 4 cycles, fetch forced on the 5th
    tick();
    bus.d_req = 1; bus.d_addr = 13'h040;
    bus.i_req = 1; bus.i_addr = 13'h010;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("s_d_gnt%0d", k), bus.d_gnt, 1);
      chk($sformatf("s_i_gnt%0d", k), bus.i_gnt, 0);
      tick();
    end
    mid();
    chk("s_force_i", bus.i_gnt, 1);
    chk("s_force_d", bus.d_gnt, 0);
    tick();
    mid();
    chk("s_after_d", bus.d_gnt, 1);
    chk("s_after_i", bus.i_gnt, 0);
    chk("s_after_iv", bus.i_rvalid, 1);
    tick();
    bus.d_req = 0;
    bus.i_req = 0;

    // byte-enabled store, then fetch it back
    tick();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 13'h020;
    bus.d_wdata = 32'hAABB_CCDD; bus.d_be = 4'b0101;
    mid();
    chk("w_d_gnt", bus.d_gnt, 1);
    chk("w_mem_we", bus.mem_we, 1);
    chk("w_mem_be", bus.mem_be, 32'h5);
    chk("w_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
    tick();
    bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_wdata = 0;
    bus.i_req = 1; bus.i_addr = 13'h020;
    mid();
    chk("w_d_rvalid", bus.d_rvalid, 1);
    chk("w_err", bus.rsp_err, 0);
    chk("w_i_gnt", bus.i_gnt, 1);
    chk("w_ram", ram[12'h020], 32'h00BB_00DD);
    tick();
    bus.i_req = 0;
    mid();
    chk("w_i_rvalid", bus.i_rvalid, 1);
    chk("w_rdata", bus.rsp_rdata, 32'h00BB_00DD);

    // out-of-range read: stale RAM data must not leak
    tick();
    bus.d_req = 1; bus.d_addr = 13'h1000;
    mid();
    chk("o_d_gnt", bus.d_gnt, 1);
    chk("o_mem_en", bus.mem_en, 0);
    tick();
    bus.d_req = 0;
    mid();
    chk("o_d_rvalid", bus.d_rvalid, 1);
    chk("o_err", bus.rsp_err, 1);
    chk("o_rdata", bus.rsp_rdata, 0);
    tick();
    mid();
    chk("o_err_clr", bus.rsp_err, 0);

    // reset the cycle after a fetch grant drops the response
    tick();
    bus.i_req = 1; bus.i_addr = 13'h010;
    bus.d_req = 1; bus.d_addr = 13'h040;
    mid();
    chk("r_d_gnt", bus.d_gnt, 1);
    tick();
    bus.d_req = 0;
    mid();
    chk("r_i_gnt", bus.i_gnt, 1);
    tick();
    bus.i_req = 0;
    bus.d_req = 1;
    rst_n = 1'b0;
    mid();
    chk("r_i_rvalid", bus.i_rvalid, 0);
    chk("r_rdata", bus.rsp_rdata, 0);
    chk("r_err", bus.rsp_err, 0);
    chk("r_d_gnt0", bus.d_gnt, 0);
    chk("r_mem_en", bus.mem_en, 0);
    chk("r_mem_addr", bus.mem_addr, 0);
    tick();
    bus.d_req = 0;
    rst_n = 1'b1;
    mid();
    chk("r_post_iv", bus.i_rvalid, 0);
    chk("r_post_dv", bus.d_rvalid, 0);
    chk("r_starve", 32'(dut.starve_q), 0);
    tick();
    mid();
    chk("r_post_iv2", bus.i_rvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port unified instruction/data memory of the rv32i core between three requesters: the program loader, the load/store unit, and instruction fetch. It grants at most one access per cycle and routes the one-cycle-latency response back to the owner. A starvation counter guarantees fetch progress under continuous data traffic. Out-of-range word addresses get an error response and never reach the RAM.

## Interface
- MEM_WORDS, 4096, memory depth in 32-bit words
- ADDR_W, 12, word-address width; MEM_WORDS <= 2**ADDR_W
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win over data

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- ld_req / ld_we  in  1  loader request / write enable
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  32  loader write data
- ld_be  in  4  loader byte enables
- ld_gnt / ld_rvalid  out  1  loader grant / response valid
- d_req / d_we  in  1  load/store request / write enable
- d_addr  in  ADDR_W  load/store word address
- d_wdata  in  32  load/store write data
- d_be  in  4  load/store byte enables
- d_gnt / d_rvalid  out  1  load/store grant / response valid
- i_req  in  1  fetch request (read only)
- i_addr  in  ADDR_W  fetch word address
- i_gnt / i_rvalid  out  1  fetch grant / response valid
- rsp_rdata  out  32  shared response data; valid only with an rvalid
- rsp_err  out  1  shared response error; valid only with an rvalid
- mem_en / mem_we  out  1  RAM enable / write enable
- mem_be  out  4  RAM byte enables
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, registered, valid the cycle after mem_en

## Operation
- Priority: loader > data > fetch. Exception: when starve_cnt == STARVE_LIMIT and i_req is high, fetch beats data. Fetch never beats the loader.
- Grants (i_gnt, d_gnt, ld_gnt) are combinational and one-hot.
  - A grant is asserted in the same cycle its req is high and that requester wins.
  - A requester holds req, address, we, wdata and be stable until it sees its gnt.
- The mem_* outputs are a combinational mux of the winning requester's command.
  - mem_en = winner exists && addr < MEM_WORDS.
  - mem_we, mem_be and mem_wdata pass through from the winner. For fetch, mem_we = 0 and mem_be = 4'hF.
  - With no winner, mem_en = 0 and all other mem_* outputs are 0.
- Response bookkeeping:
  - Registered owner (none/ld/d/i) and err_q capture the winner and out-of-range status on each grant.
  - The next cycle, the owner's rvalid pulses for one cycle, for both reads and writes. A write's rvalid is its acknowledge.
  - rsp_rdata = err_q ? 0 : mem_rdata.
  - rsp_err = err_q.
  - Without an rvalid, rsp_rdata = 0 and rsp_err = 0.
- Out-of-range access (addr >= MEM_WORDS): granted normally, RAM untouched, rvalid next cycle with rsp_err = 1 and rsp_rdata = 0.
- Starvation counter (saturating, width $clog2(STARVE_LIMIT+1)):
  - Increments each cycle i_req is high and fetch is not granted.
  - Clears on i_gnt or when i_req is low.
- Reset values: owner = none, err_q = 0, starve_cnt = 0. All gnt and rvalid outputs are 0 while rst_n is low. The mem_* outputs are 0 while rst_n is low, because every req is ignored in reset.

## Timing
- Throughput: one grant per cycle, back-to-back allowed, no bubbles. Owner switching costs zero cycles.
- Latency: gnt in cycle N, rvalid and rsp_* in cycle N+1.
- A grant in N+1 may coexist with the N response. Rvalid and gnt refer to different accesses.
- Simultaneous requests: only the winner sees gnt. Losers keep req high and are re-evaluated every cycle.
- Reset asserted mid-access: the in-flight response is dropped. No rvalid appears after rst_n deasserts until a new grant occurs.
- First grant is possible in the first cycle rst_n is high at the posedge.

## Test plan
- Single fetch read of addr 0x010 with RAM[0x010] = 0x00000013 -> i_gnt in cycle N; i_rvalid, rsp_rdata = 0x00000013 and rsp_err = 0 in N+1.
- ld, d and i all request in the same cycle -> ld_gnt only. With ld_req dropped, d_gnt next cycle, then i_gnt. Each rvalid follows its grant by exactly one cycle.
- d_req held high continuously with i_req high, STARVE_LIMIT = 4 -> d_gnt for 4 cycles, i_gnt in cycle 5, then the counter clears and data wins again.
- Store d_we = 1, addr 0x020, d_wdata = 0xAABBCCDD, d_be = 4'b0101, RAM previously 0 -> RAM = 0x00BB00DD. A fetch of 0x020 then returns 0x00BB00DD.
- d read of addr MEM_WORDS (0x1000 with ADDR_W = 13) -> d_gnt, mem_en = 0, d_rvalid next cycle with rsp_err = 1 and rsp_rdata = 0.
- rst_n pulled low the cycle after an i_gnt -> no i_rvalid appears. All outputs are 0 during reset and starve_cnt reads 0 afterwards.
